// File: rtl/exec_pkg.sv
// exec_pkg: shared definitions for the execution stage.
//   - opcode encodings for single-cycle, branch and multi-cycle ops
//   - FSM state encoding
//   - fixed results for divide-by-zero and signed overflow
package exec_pkg;

   localparam logic [5:0] OP_LUI  = 6'b110000;
   localparam logic [5:0] OP_ADD  = 6'b001100;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_SUB  = 6'b010100;
   localparam logic [5:0] OP_SLL  = 6'b011100;
   localparam logic [5:0] OP_SLLI = 6'b011000;
   localparam logic [5:0] OP_SRL  = 6'b100100;
   localparam logic [5:0] OP_SRLI = 6'b100000;
   localparam logic [5:0] OP_SRA  = 6'b101100;
   localparam logic [5:0] OP_SRAI = 6'b101000;
   localparam logic [5:0] OP_JAL  = 6'b000110;
   localparam logic [5:0] OP_JALR = 6'b001110;
   localparam logic [5:0] OP_J    = 6'b000010;
   localparam logic [5:0] OP_JR   = 6'b001010;
   localparam logic [5:0] OP_BEQ  = 6'b010010;
   localparam logic [5:0] OP_BLE  = 6'b011010;
   localparam logic [5:0] OP_BEQI = 6'b110010;
   localparam logic [5:0] OP_BNEI = 6'b111010;
   localparam logic [5:0] OP_BLEI = 6'b100010;
   localparam logic [5:0] OP_BGEI = 6'b101010;
   localparam logic [5:0] OP_MUL  = 6'b110100;
   localparam logic [5:0] OP_DIV  = 6'b111100;
   localparam logic [5:0] OP_REM  = 6'b000100;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      MUL_WAIT = 2'd1,
      DIV_RUN  = 2'd2,
      DIV_FIX  = 2'd3
   } state_t;

   // x/0: quotient is all ones, remainder passes the dividend through.
   localparam logic [63:0] DIV0_QUOT = '1;
   // MIN/-1: quotient is MIN itself, remainder is zero.
   localparam logic [63:0] OVF_REM   = '0;

   // Most negative value of an xlen-bit word (also the MIN/-1 quotient).
   function automatic logic [63:0] ovf_quot(input int xlen);
      return 64'd1 << (xlen - 1);
   endfunction

endpackage

// File: rtl/exec_unit_div_iter.sv
// div_iter: iterative signed divider.
//   One restoring iteration per cycle on operand magnitudes, XLEN
//   iterations, followed by one cycle in which done is high and the
//   sign-corrected quotient/remainder are presented.
// Ports:
//   clk, rstn          clock, synchronous active-low reset
//   start              load operands and begin (ignored while kill)
//   kill               abandon any operation in progress
//   dividend, divisor  signed operands, sampled on start
//   done               high for the single result cycle
//   quotient           truncated toward zero
//   remainder          sign follows the dividend
module div_iter
   import exec_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic            start,
   input  logic            kill,
   input  logic [XLEN-1:0] dividend,
   input  logic [XLEN-1:0] divisor,
   output logic            done,
   output logic [XLEN-1:0] quotient,
   output logic [XLEN-1:0] remainder
);

   localparam int CW = $clog2(XLEN);
   localparam logic [XLEN-1:0] MIN_VAL = XLEN'(ovf_quot(XLEN));

   logic            run;
   logic            fix;
   logic [CW-1:0]   cnt;
   logic [XLEN-1:0] quo;
   logic [XLEN-1:0] rem;
   logic [XLEN-1:0] dvs;
   logic [XLEN-1:0] dvd_q;
   logic            q_neg;
   logic            r_neg;
   logic            div0;
   logic            ovf;

   logic [XLEN-1:0] a_mag;
   logic [XLEN-1:0] b_mag;
   logic [XLEN:0]   shifted;
   logic [XLEN:0]   trial;

   // Magnitude of MIN wraps to itself, which is correct when read unsigned.
   assign a_mag   = dividend[XLEN-1] ? -dividend : dividend;
   assign b_mag   = divisor[XLEN-1]  ? -divisor  : divisor;
   assign shifted = {rem, quo[XLEN-1]};
   assign trial   = shifted - {1'b0, dvs};

   always_ff @(posedge clk) begin
      if (!rstn) begin
         run   <= 1'b0;
         fix   <= 1'b0;
         cnt   <= '0;
         quo   <= '0;
         rem   <= '0;
         dvs   <= '0;
         dvd_q <= '0;
         q_neg <= 1'b0;
         r_neg <= 1'b0;
         div0  <= 1'b0;
         ovf   <= 1'b0;
      end else if (kill) begin
         run <= 1'b0;
         fix <= 1'b0;
      end else if (start) begin
         run   <= 1'b1;
         fix   <= 1'b0;
         cnt   <= CW'(XLEN - 1);
         quo   <= a_mag;
         rem   <= '0;
         dvs   <= b_mag;
         dvd_q <= dividend;
         q_neg <= dividend[XLEN-1] ^ divisor[XLEN-1];
         r_neg <= dividend[XLEN-1];
         div0  <= (divisor == '0);
         ovf   <= (dividend == MIN_VAL) && (divisor == '1);
      end else if (run) begin
         if (!trial[XLEN]) begin
            rem <= trial[XLEN-1:0];
            quo <= {quo[XLEN-2:0], 1'b1};
         end else begin
            rem <= shifted[XLEN-1:0];
            quo <= {quo[XLEN-2:0], 1'b0};
         end
         if (cnt == '0) begin
            run <= 1'b0;
            fix <= 1'b1;
         end else begin
            cnt <= cnt - CW'(1);
         end
      end else begin
         fix <= 1'b0;
      end
   end

   assign done      = fix;
   assign quotient  = div0 ? XLEN'(DIV0_QUOT) :
                      ovf  ? MIN_VAL :
                      (q_neg ? -quo : quo);
   assign remainder = div0 ? dvd_q :
                      ovf  ? XLEN'(OVF_REM) :
                      (r_neg ? -rem : rem);

endmodule

// File: rtl/exec_unit.sv
// exec_unit: integer/branch execution stage with multi-cycle MUL/DIV/REM.
//   Branches resolve combinationally; single-cycle ALU results are
//   registered to the writeback port one cycle after accept. MUL results
//   appear MUL_LAT cycles after accept, DIV/REM after XLEN+2 cycles.
// Ports:
//   clk, rstn            clock, synchronous active-low reset
//   in_valid, flush      op presented / abort multi-cycle op
//   pc, ope, ds_val,
//   dt_val, dd, imm, opr op fields and operands
//   busy                 op will not be accepted this cycle
//   b_taken, b_addr      combinational branch resolution
//   wb_valid, wb_addr,
//   wb_val               registered writeback
//
// state    | meaning
// ---------+-------------------------------------------------
// IDLE     | accepting ops, single-cycle results written here
// MUL_WAIT | product travelling down the delay line
// DIV_RUN  | divider iterating on magnitudes
// DIV_FIX  | divider sign correction, result written on exit
module exec_unit
   import exec_pkg::*;
#(
   parameter int XLEN     = 32,
   parameter int PC_W     = 14,
   parameter int REG_W    = 6,
   parameter int LINK_REG = 31,
   parameter int MUL_LAT  = 2
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             in_valid,
   input  logic             flush,
   input  logic [PC_W-1:0]  pc,
   input  logic [5:0]       ope,
   input  logic [XLEN-1:0]  ds_val,
   input  logic [XLEN-1:0]  dt_val,
   input  logic [REG_W-1:0] dd,
   input  logic [15:0]      imm,
   input  logic [4:0]       opr,
   output logic             busy,
   output logic             b_taken,
   output logic [PC_W-1:0]  b_addr,
   output logic             wb_valid,
   output logic [REG_W-1:0] wb_addr,
   output logic [XLEN-1:0]  wb_val
);

   localparam int SW = $clog2(XLEN);
   localparam int CW = $clog2(XLEN + MUL_LAT) + 1;

   state_t           state;
   logic [CW-1:0]    cnt;
   logic [REG_W-1:0] dd_q;
   logic             is_rem_q;
   logic [XLEN-1:0]  mul_pipe [MUL_LAT-1];

   logic             accept;
   logic             is_mul;
   logic             is_div;
   logic [XLEN-1:0]  imm_sx;
   logic [XLEN-1:0]  opr_sx;
   logic [XLEN-1:0]  op_b;
   logic [SW-1:0]    shamt;
   logic [XLEN-1:0]  lui_val;
   logic [PC_W:0]    pc_inc;
   logic [REG_W-1:0] sc_addr;
   logic [XLEN-1:0]  sc_val;
   logic             b_cond;
   logic             div_done;
   logic [XLEN-1:0]  div_q;
   logic [XLEN-1:0]  div_r;

   assign busy   = (state != IDLE);
   assign accept = in_valid && !busy;
   assign is_mul = (ope == OP_MUL);
   assign is_div = (ope == OP_DIV) || (ope == OP_REM);
   assign imm_sx = XLEN'($signed(imm));
   assign opr_sx = XLEN'($signed(opr));
   assign op_b   = ope[2] ? dt_val : imm_sx;
   assign shamt  = op_b[SW-1:0];
   assign pc_inc = {1'b0, pc} + (PC_W + 1)'(1);

   generate
      if (XLEN >= 16) begin : g_lui
         assign lui_val = XLEN'({imm, ds_val[15:0]});
      end else begin : g_lui_narrow
         assign lui_val = ds_val;
      end
   endgenerate

   always_comb begin
      sc_addr = dd;
      sc_val  = '0;
      case (ope)
         OP_LUI:           sc_val = lui_val;
         OP_ADD, OP_ADDI:  sc_val = ds_val + op_b;
         OP_SUB:           sc_val = ds_val - op_b;
         OP_SLL, OP_SLLI:  sc_val = ds_val << shamt;
         OP_SRL, OP_SRLI:  sc_val = ds_val >> shamt;
         OP_SRA, OP_SRAI:  sc_val = $unsigned($signed(ds_val) >>> shamt);
         OP_JAL, OP_JALR: begin
            sc_addr = REG_W'(LINK_REG);
            sc_val  = XLEN'(pc_inc);
         end
         default:          sc_addr = '0;
      endcase
   end

   always_comb begin
      b_cond = 1'b0;
      case (ope)
         OP_BEQ:  b_cond = (ds_val == dt_val);
         OP_BLE:  b_cond = ($signed(ds_val) <= $signed(dt_val));
         OP_BEQI: b_cond = (ds_val == opr_sx);
         OP_BNEI: b_cond = (ds_val != opr_sx);
         OP_BLEI: b_cond = ($signed(ds_val) <= $signed(opr_sx));
         OP_BGEI: b_cond = ($signed(ds_val) >= $signed(opr_sx));
         default: b_cond = 1'b0;
      endcase
   end

   assign b_taken = in_valid && b_cond;
   assign b_addr  = imm[PC_W-1:0];

   // Stage 0 only loads on a MUL accept so the product survives while busy.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         for (int i = 0; i < MUL_LAT - 1; i++) mul_pipe[i] <= '0;
      end else begin
         if (accept && is_mul) mul_pipe[0] <= ds_val * dt_val;
         for (int i = 1; i < MUL_LAT - 1; i++) mul_pipe[i] <= mul_pipe[i-1];
      end
   end

   div_iter #(.XLEN(XLEN)) u_div (
      .clk       (clk),
      .rstn      (rstn),
      .start     (accept && is_div && !flush),
      .kill      (flush),
      .dividend  (ds_val),
      .divisor   (dt_val),
      .done      (div_done),
      .quotient  (div_q),
      .remainder (div_r)
   );

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state    <= IDLE;
         cnt      <= '0;
         dd_q     <= '0;
         is_rem_q <= 1'b0;
         wb_valid <= 1'b0;
         wb_addr  <= '0;
         wb_val   <= '0;
      end else begin
         wb_valid <= 1'b0;
         wb_addr  <= '0;
         wb_val   <= '0;
         case (state)
            IDLE: begin
               if (accept) begin
                  if (is_mul) begin
                     if (!flush) state <= MUL_WAIT;
                     cnt  <= CW'(MUL_LAT - 2);
                     dd_q <= dd;
                  end else if (is_div) begin
                     if (!flush) state <= DIV_RUN;
                     cnt      <= CW'(XLEN - 1);
                     dd_q     <= dd;
                     is_rem_q <= (ope == OP_REM);
                  end else begin
                     wb_valid <= (sc_addr != '0);
                     wb_addr  <= sc_addr;
                     wb_val   <= sc_val;
                  end
               end
            end
            MUL_WAIT: begin
               if (flush) begin
                  state <= IDLE;
               end else if (cnt == '0) begin
                  state    <= IDLE;
                  wb_valid <= (dd_q != '0);
                  wb_addr  <= dd_q;
                  wb_val   <= mul_pipe[MUL_LAT-2];
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            DIV_RUN: begin
               if (flush) begin
                  state <= IDLE;
               end else if (cnt == '0) begin
                  state <= DIV_FIX;
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            DIV_FIX: begin
               state <= IDLE;
               if (!flush && div_done) begin
                  wb_valid <= (dd_q != '0);
                  wb_addr  <= dd_q;
                  wb_val   <= is_rem_q ? div_r : div_q;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_exec_unit.sv
module tb_exec_unit;

   localparam logic [5:0] T_LUI  = 6'b110000;
   localparam logic [5:0] T_ADD  = 6'b001100;
   localparam logic [5:0] T_ADDI = 6'b001000;
   localparam logic [5:0] T_SUB  = 6'b010100;
   localparam logic [5:0] T_SLL  = 6'b011100;
   localparam logic [5:0] T_SRL  = 6'b100100;
   localparam logic [5:0] T_SRAI = 6'b101000;
   localparam logic [5:0] T_JAL  = 6'b000110;
   localparam logic [5:0] T_J    = 6'b000010;
   localparam logic [5:0] T_BEQ  = 6'b010010;
   localparam logic [5:0] T_BLE  = 6'b011010;
   localparam logic [5:0] T_BEQI = 6'b110010;
   localparam logic [5:0] T_BNEI = 6'b111010;
   localparam logic [5:0] T_BLEI = 6'b100010;
   localparam logic [5:0] T_BGEI = 6'b101010;
   localparam logic [5:0] T_MUL  = 6'b110100;
   localparam logic [5:0] T_DIV  = 6'b111100;
   localparam logic [5:0] T_REM  = 6'b000100;

   logic        clk = 1'b0;
   logic        rstn;
   logic        in_valid;
   logic        flush;
   logic [13:0] pc;
   logic [5:0]  ope;
   logic [31:0] ds_val;
   logic [31:0] dt_val;
   logic [5:0]  dd;
   logic [15:0] imm;
   logic [4:0]  opr;
   logic        busy;
   logic        b_taken;
   logic [13:0] b_addr;
   logic        wb_valid;
   logic [5:0]  wb_addr;
   logic [31:0] wb_val;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   exec_unit #(.XLEN(32), .PC_W(14), .REG_W(6), .LINK_REG(31), .MUL_LAT(2)) dut (
      .clk(clk), .rstn(rstn), .in_valid(in_valid), .flush(flush), .pc(pc),
      .ope(ope), .ds_val(ds_val), .dt_val(dt_val), .dd(dd), .imm(imm),
      .opr(opr), .busy(busy), .b_taken(b_taken), .b_addr(b_addr),
      .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_val(wb_val)
   );

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_in;
      in_valid = 1'b0; flush = 1'b0; pc = '0; ope = T_J;
      ds_val = '0; dt_val = '0; dd = '0; imm = '0; opr = '0;
   endtask

   task automatic set_op(input logic [5:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [5:0] d, input logic [15:0] i);
      in_valid = 1'b1; ope = o; ds_val = a; dt_val = b; dd = d; imm = i;
   endtask

   // Single-cycle vectors: op, ds, dt, imm, pc, dd -> valid, addr, value
   localparam int NA = 9;
   logic [5:0]  av_o  [NA] = '{T_ADDI, T_SUB, T_SRAI, T_SLL, T_SRL, T_LUI, T_JAL, T_J, T_ADD};
   logic [31:0] av_a  [NA] = '{32'd5, 32'd10, 32'h8000_0000, 32'd1, 32'h8000_0000,
                               32'hAAAA_5678, 32'd0, 32'd0, 32'd1};
   logic [31:0] av_b  [NA] = '{32'd0, 32'd3, 32'd0, 32'd35, 32'h3F, 32'd0, 32'd0, 32'd0, 32'd1};
   logic [15:0] av_i  [NA] = '{16'hFFFF, 16'd0, 16'd4, 16'd0, 16'd0, 16'h1234, 16'd0, 16'd0, 16'd0};
   logic [13:0] av_p  [NA] = '{14'd0, 14'd0, 14'd0, 14'd0, 14'd0, 14'd0, 14'h3FFF, 14'd0, 14'd0};
   logic [5:0]  av_d  [NA] = '{6'd3, 6'd4, 6'd5, 6'd6, 6'd7, 6'd8, 6'd5, 6'd7, 6'd0};
   logic        av_v  [NA] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
   logic [5:0]  av_ea [NA] = '{6'd3, 6'd4, 6'd5, 6'd6, 6'd7, 6'd8, 6'd31, 6'd0, 6'd0};
   logic [31:0] av_ev [NA] = '{32'd4, 32'd7, 32'hF800_0000, 32'd8, 32'd1, 32'h1234_5678,
                               32'h0000_4000, 32'd0, 32'd0};

   // Branch vectors: op, ds, dt, opr, in_valid -> taken
   localparam int NB = 9;
   logic [5:0]  bv_o [NB] = '{T_BLEI, T_BGEI, T_BEQI, T_BNEI, T_BNEI, T_BLE, T_BLE, T_BEQ, T_BGEI};
   logic [31:0] bv_a [NB] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'd3,
                              32'hFFFF_FFFB, 32'd3, 32'd7, 32'h10};
   logic [31:0] bv_b [NB] = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd3, 32'hFFFF_FFFB, 32'd7, 32'd0};
   logic [4:0]  bv_r [NB] = '{5'd0, 5'd0, 5'b11101, 5'b11101, 5'd4, 5'd0, 5'd0, 5'd0, 5'd15};
   logic        bv_v [NB] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
   logic        bv_t [NB] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

   // Divider vectors: op, ds, dt -> result
   localparam int ND = 10;
   logic [5:0]  dv_o [ND] = '{T_DIV, T_REM, T_DIV, T_REM, T_DIV, T_REM, T_DIV, T_REM, T_DIV, T_REM};
   logic [31:0] dv_a [ND] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd7, 32'd7, 32'd100, 32'hFFFF_FFF7,
                              32'h8000_0000, 32'h8000_0000, 32'd1000, 32'd1000};
   logic [31:0] dv_b [ND] = '{32'd2, 32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'd0, 32'd0,
                              32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd7, 32'd7};
   logic [31:0] dv_e [ND] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'd1, 32'hFFFF_FFFF,
                              32'hFFFF_FFF7, 32'h8000_0000, 32'd0, 32'd142, 32'd6};

   task automatic test_reset;
      idle_in();
      rstn = 1'b0;
      tick(); tick();
      n_cmp++;
      if ({busy, wb_valid, wb_addr, wb_val} !== 40'd0) begin
         n_err++;
         $display("FAIL reset_outputs: got busy=%b wb_valid=%b wb_addr=%0d wb_val=%h, expected all 0",
                  busy, wb_valid, wb_addr, wb_val);
      end
      rstn = 1'b1;
      tick();
   endtask

   task automatic test_alu;
      for (int i = 0; i < NA; i++) begin
         set_op(av_o[i], av_a[i], av_b[i], av_d[i], av_i[i]);
         pc = av_p[i];
         tick();
         n_cmp++;
         if (wb_valid !== av_v[i]) begin
            n_err++;
            $display("FAIL alu_valid[%0d]: got %b expected %b", i, wb_valid, av_v[i]);
         end
         n_cmp++;
         if (wb_addr !== av_ea[i]) begin
            n_err++;
            $display("FAIL alu_addr[%0d]: got %0d expected %0d", i, wb_addr, av_ea[i]);
         end
         if (av_v[i]) begin
            n_cmp++;
            if (wb_val !== av_ev[i]) begin
               n_err++;
               $display("FAIL alu_val[%0d]: got %h expected %h", i, wb_val, av_ev[i]);
            end
         end
      end
      idle_in();
      tick();
      n_cmp++;
      if (wb_valid !== 1'b0) begin
         n_err++;
         $display("FAIL alu_single_pulse: got wb_valid=%b expected 0", wb_valid);
      end
   endtask

   task automatic test_branch;
      for (int i = 0; i < NB; i++) begin
         in_valid = bv_v[i]; ope = bv_o[i]; ds_val = bv_a[i]; dt_val = bv_b[i];
         opr = bv_r[i]; dd = 6'd9; imm = 16'hC123;
         #1;
         n_cmp++;
         if (b_taken !== bv_t[i]) begin
            n_err++;
            $display("FAIL branch_taken[%0d]: got %b expected %b", i, b_taken, bv_t[i]);
         end
      end
      n_cmp++;
      if (b_addr !== 14'h0123) begin
         n_err++;
         $display("FAIL branch_addr: got %h expected 0123", b_addr);
      end
      tick();
      idle_in();
      n_cmp++;
      if (wb_valid !== 1'b0) begin
         n_err++;
         $display("FAIL branch_no_wb: got wb_valid=%b expected 0", wb_valid);
      end
      tick();
   endtask

   task automatic test_mul;
      logic [31:0] ma [2] = '{32'h7FFF_FFFF, 32'hFFFF_FFFD};
      logic [31:0] mb [2] = '{32'd3, 32'd5};
      logic [31:0] me [2] = '{32'h7FFF_FFFD, 32'hFFFF_FFF1};
      for (int i = 0; i < 2; i++) begin
         set_op(T_MUL, ma[i], mb[i], 6'd9, 16'd0);
         tick();
         n_cmp++;
         if (busy !== 1'b1 || wb_valid !== 1'b0) begin
            n_err++;
            $display("FAIL mul_busy[%0d]: got busy=%b wb_valid=%b expected 1/0", i, busy, wb_valid);
         end
         set_op(T_BEQ, 32'd7, 32'd7, 6'd0, 16'd0);
         #1;
         n_cmp++;
         if (b_taken !== 1'b1) begin
            n_err++;
            $display("FAIL beq_while_busy[%0d]: got %b expected 1", i, b_taken);
         end
         idle_in();
         tick();
         n_cmp++;
         if (busy !== 1'b0 || wb_valid !== 1'b1 || wb_addr !== 6'd9) begin
            n_err++;
            $display("FAIL mul_wb[%0d]: got busy=%b wb_valid=%b wb_addr=%0d expected 0/1/9",
                     i, busy, wb_valid, wb_addr);
         end
         n_cmp++;
         if (wb_val !== me[i]) begin
            n_err++;
            $display("FAIL mul_val[%0d]: got %h expected %h", i, wb_val, me[i]);
         end
         tick();
         n_cmp++;
         if (wb_valid !== 1'b0) begin
            n_err++;
            $display("FAIL mul_single_pulse[%0d]: got %b expected 0", i, wb_valid);
         end
      end
   endtask

   task automatic test_back_to_back;
      set_op(T_MUL, 32'd6, 32'd7, 6'd11, 16'd0);
      tick();
      set_op(T_ADD, 32'd1, 32'd2, 6'd12, 16'd0);
      tick();
      n_cmp++;
      if (wb_valid !== 1'b1 || wb_addr !== 6'd11 || wb_val !== 32'd42) begin
         n_err++;
         $display("FAIL b2b_mul: got v=%b a=%0d d=%h expected 1/11/0000002a", wb_valid, wb_addr, wb_val);
      end
      tick();
      idle_in();
      n_cmp++;
      if (wb_valid !== 1'b1 || wb_addr !== 6'd12 || wb_val !== 32'd3) begin
         n_err++;
         $display("FAIL b2b_add: got v=%b a=%0d d=%h expected 1/12/00000003", wb_valid, wb_addr, wb_val);
      end
      tick();
      n_cmp++;
      if (wb_valid !== 1'b0) begin
         n_err++;
         $display("FAIL b2b_idle: got wb_valid=%b expected 0", wb_valid);
      end
   endtask

   task automatic test_div;
      int lat;
      int bcnt;
      for (int i = 0; i < ND; i++) begin
         set_op(dv_o[i], dv_a[i], dv_b[i], 6'd13, 16'd0);
         tick();
         idle_in();
         lat = 1;
         bcnt = 0;
         while (wb_valid !== 1'b1 && lat < 60) begin
            if (busy === 1'b1) bcnt++;
            tick();
            lat++;
         end
         n_cmp++;
         if (lat != 34) begin
            n_err++;
            $display("FAIL div_latency[%0d]: got %0d cycles expected 34", i, lat);
         end
         n_cmp++;
         if (bcnt != 33) begin
            n_err++;
            $display("FAIL div_busy_cycles[%0d]: got %0d expected 33", i, bcnt);
         end
         n_cmp++;
         if (busy !== 1'b0 || wb_addr !== 6'd13) begin
            n_err++;
            $display("FAIL div_wb[%0d]: got busy=%b wb_addr=%0d expected 0/13", i, busy, wb_addr);
         end
         n_cmp++;
         if (wb_val !== dv_e[i]) begin
            n_err++;
            $display("FAIL div_val[%0d]: got %h expected %h", i, wb_val, dv_e[i]);
         end
      end
      tick();
   endtask

   task automatic test_flush;
      int seen;
      set_op(T_DIV, 32'd100, 32'd3, 6'd14, 16'd0);
      tick();
      idle_in();
      repeat (9) tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      n_cmp++;
      if (busy !== 1'b0 || wb_valid !== 1'b0) begin
         n_err++;
         $display("FAIL flush_div: got busy=%b wb_valid=%b expected 0/0", busy, wb_valid);
      end
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (wb_valid === 1'b1) seen++;
      end
      n_cmp++;
      if (seen != 0) begin
         n_err++;
         $display("FAIL flush_no_late_wb: got %0d writebacks expected 0", seen);
      end

      set_op(T_MUL, 32'd3, 32'd3, 6'd15, 16'd0);
      flush = 1'b1;
      tick();
      idle_in();
      n_cmp++;
      if (busy !== 1'b0) begin
         n_err++;
         $display("FAIL flush_mul_accept: got busy=%b expected 0", busy);
      end
      tick();
      n_cmp++;
      if (wb_valid !== 1'b0) begin
         n_err++;
         $display("FAIL flush_mul_no_wb: got wb_valid=%b expected 0", wb_valid);
      end

      set_op(T_DIV, 32'd9, 32'd3, 6'd15, 16'd0);
      flush = 1'b1;
      tick();
      idle_in();
      n_cmp++;
      if (busy !== 1'b0) begin
         n_err++;
         $display("FAIL flush_div_accept: got busy=%b expected 0", busy);
      end

      set_op(T_ADD, 32'd2, 32'd3, 6'd16, 16'd0);
      flush = 1'b1;
      tick();
      idle_in();
      n_cmp++;
      if (wb_valid !== 1'b1 || wb_addr !== 6'd16 || wb_val !== 32'd5) begin
         n_err++;
         $display("FAIL flush_single_cycle: got v=%b a=%0d d=%h expected 1/16/00000005",
                  wb_valid, wb_addr, wb_val);
      end

      set_op(T_MUL, 32'd4, 32'd4, 6'd17, 16'd0);
      tick();
      idle_in();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      n_cmp++;
      if (busy !== 1'b0 || wb_valid !== 1'b0) begin
         n_err++;
         $display("FAIL flush_mul_wait: got busy=%b wb_valid=%b expected 0/0", busy, wb_valid);
      end
      tick();
   endtask

   task automatic test_reset_mid;
      int seen;
      set_op(T_DIV, 32'd100, 32'd3, 6'd18, 16'd0);
      tick();
      idle_in();
      repeat (5) tick();
      rstn = 1'b0;
      tick();
      n_cmp++;
      if ({busy, wb_valid, wb_addr, wb_val} !== 40'd0) begin
         n_err++;
         $display("FAIL reset_mid_div: got busy=%b wb_valid=%b wb_addr=%0d wb_val=%h expected all 0",
                  busy, wb_valid, wb_addr, wb_val);
      end
      rstn = 1'b1;
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (wb_valid === 1'b1) seen++;
      end
      n_cmp++;
      if (seen != 0) begin
         n_err++;
         $display("FAIL reset_no_late_wb: got %0d writebacks expected 0", seen);
      end
      set_op(T_ADDI, 32'd20, 32'd0, 6'd19, 16'hFFF6);
      tick();
      idle_in();
      n_cmp++;
      if (wb_valid !== 1'b1 || wb_addr !== 6'd19 || wb_val !== 32'd10) begin
         n_err++;
         $display("FAIL reset_then_addi: got v=%b a=%0d d=%h expected 1/19/0000000a",
                  wb_valid, wb_addr, wb_val);
      end
      tick();
   endtask

   initial begin
      idle_in();
      rstn = 1'b0;
      test_reset();
      test_alu();
      test_branch();
      test_mul();
      test_back_to_back();
      test_div();
      test_flush();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
